demux8_tdm_rx: RTL and testbench

DEMUX8_TDM_RX -- requirements
Module: demux8_tdm_rx

---
 rtl/demux8_tdm_rx.sv | 138 +++++++++++++
 tb/tb_demux8_tdm_rx.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/demux8_tdm_rx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : demux8_tdm_rx
// Brief    : 8-slot serial TDM receiver; slot 0 marked by frame sync, optional
//            even-parity slot when DEMUX_PARITY_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module demux8_tdm_rx #(
  parameter logic SYNC_ACTIVE = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       d,
  input  logic       s,
  input  logic       en,
  output logic [7:0] y,
  output logic       valid,
  output logic [2:0] slot,
  output logic       err
);

`ifdef DEMUX_PARITY_EN
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_PAR  = 2'd2
  } state_t;
`else
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1
  } state_t;
`endif

  state_t     r_state, w_state_nxt;
  logic [2:0] r_slot, w_slot_nxt;
  logic [7:0] r_buf, w_buf_nxt;
  logic [7:0] r_y, w_y_nxt;
  logic       r_valid, w_valid_nxt;
  logic       r_err, w_err_nxt;
  logic       w_sync;
  logic       w_last;

  assign w_sync = (s == SYNC_ACTIVE);
  assign w_last = (r_slot == 3'd7);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_slot  <= 3'd0;
      r_buf   <= 8'h00;
      r_y     <= 8'h00;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_slot  <= w_slot_nxt;
      r_buf   <= w_buf_nxt;
      r_y     <= w_y_nxt;
      r_valid <= w_valid_nxt;
      r_err   <= w_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_slot_nxt  = r_slot;
    w_buf_nxt   = r_buf;
    w_y_nxt     = r_y;
    w_valid_nxt = 1'b0;
    w_err_nxt   = 1'b0;
    if (en) begin
      case (r_state)
        ST_IDLE: begin
          if (w_sync) begin
            w_buf_nxt   = {7'd0, d};
            w_slot_nxt  = 3'd1;
            w_state_nxt = ST_RUN;
          end
        end
        ST_RUN: begin
          if (w_sync) begin
            // Sync inside a frame: drop the partial frame and treat d as slot 0
            w_err_nxt  = 1'b1;
            w_buf_nxt  = {7'd0, d};
            w_slot_nxt = 3'd1;
          end else begin
            w_buf_nxt[r_slot] = d;
            if (w_last) begin
              w_slot_nxt = 3'd0;
`ifdef DEMUX_PARITY_EN
              w_state_nxt = ST_PAR;
`else
              w_y_nxt     = {d, r_buf[6:0]};
              w_valid_nxt = 1'b1;
              w_state_nxt = ST_IDLE;
`endif
            end else begin
              w_slot_nxt = r_slot + 3'd1;
            end
          end
        end
`ifdef DEMUX_PARITY_EN
        ST_PAR: begin
          if (w_sync) begin
            w_err_nxt   = 1'b1;
            w_buf_nxt   = {7'd0, d};
            w_slot_nxt  = 3'd1;
            w_state_nxt = ST_RUN;
          end else begin
            // Even parity: data bits plus parity bit must XOR to zero
            if ((^r_buf ^ d) == 1'b0) begin
              w_y_nxt     = r_buf;
              w_valid_nxt = 1'b1;
            end else begin
              w_err_nxt = 1'b1;
            end
            w_slot_nxt  = 3'd0;
            w_state_nxt = ST_IDLE;
          end
        end
`endif
        default: begin
          w_state_nxt = ST_IDLE;
          w_slot_nxt  = 3'd0;
        end
      endcase
    end
  end

  assign y     = r_y;
  assign valid = r_valid;
  assign slot  = r_slot;
  assign err   = r_err;

endmodule
`default_nettype wire

// File: tb/tb_demux8_tdm_rx.sv
`timescale 1ns/1ps
`default_nettype none
// Testbench for demux8_tdm_rx: queue-based frame model, per-cycle compare,
// directed frames plus randomized strobes/syncs.
module tb_demux8_tdm_rx;
  localparam logic SYNC = 1'b1;
`ifdef DEMUX_PARITY_EN
  localparam int FRAME_LEN = 9;
`else
  localparam int FRAME_LEN = 8;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       d, s, en;
  logic [7:0] y;
  logic       valid, err;
  logic [2:0] slot;

  int n_vec  = 0;
  int n_fail = 0;
  int n_chk  = 0;
  bit checking = 0;

  demux8_tdm_rx #(.SYNC_ACTIVE(SYNC)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (d),
    .s     (s),
    .en    (en),
    .y     (y),
    .valid (valid),
    .slot  (slot),
    .err   (err)
  );

  always #5 clk = ~clk;

  // Reference model: bits of the frame in progress, oldest first
  bit         q[$];
  logic [7:0] m_y;
  bit         m_valid, m_err;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      m_y = 8'h00; m_valid = 0; m_err = 0;
    end else begin
      m_valid = 0; m_err = 0;
      if (en) begin
        if (s == SYNC) begin
          if (q.size() > 0) m_err = 1;
          q.delete();
          q.push_back(d);
        end else if (q.size() > 0) begin
          q.push_back(d);
          if (q.size() == FRAME_LEN) begin
            logic [7:0] w;
            bit par;
            par = 0;
            for (int i = 0; i < 8; i++) w[i] = q[i];
            for (int i = 0; i < FRAME_LEN; i++) par = par ^ q[i];
            if (par == 0 || FRAME_LEN == 8) begin m_y = w; m_valid = 1; end
            else m_err = 1;
            q.delete();
          end
        end
      end
    end
  end

  function automatic logic [7:0] m_slot();
    return (q.size() < 8) ? 8'(q.size()) : 8'd0;
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (checking) begin
      chk("model_y", y, m_y);
      chk("model_valid", {7'd0, valid}, {7'd0, m_valid});
      chk("model_err", {7'd0, err}, {7'd0, m_err});
      chk("model_slot", {5'd0, slot}, m_slot());
    end
  end

  task automatic step(input logic e, input logic ss, input logic dd);
    en = e; s = ss; d = dd;
    n_vec++;
    @(posedge clk); #1;
  endtask

  task automatic gap_cycles(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
  endtask

  // Sends slots 0..7 (plus parity when enabled); checks literal results
  task automatic send_frame(input logic [7:0] v, input int gap, input bit exp_err0,
                            input bit par_flip);
    for (int k = 0; k < 8; k++) begin
      step(1'b1, (k == 0) ? SYNC : ~SYNC, v[k]);
      if (k == 0) chk("first_slot_err", {7'd0, err}, {7'd0, exp_err0});
      if (gap > 0 && k < 7) begin
        gap_cycles(gap);
        chk("gap_slot", {5'd0, slot}, 8'(k + 1));
      end
    end
`ifdef DEMUX_PARITY_EN
    step(1'b1, ~SYNC, (^v) ^ par_flip);
`endif
  endtask

  task automatic send_partial(input logic [7:0] v, input int n);
    for (int k = 0; k < n; k++) step(1'b1, (k == 0) ? SYNC : ~SYNC, v[k]);
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; s = 1'b0; d = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_y", y, 8'h00);
    chk("reset_slot", {5'd0, slot}, 8'd0);
    chk("reset_valid", {7'd0, valid}, 8'd0);
    checking = 1;
    rst_n = 1'b1;

    // Data without sync is discarded
    repeat (3) step(1'b1, ~SYNC, 1'b1);
    chk("idle_slot", {5'd0, slot}, 8'd0);

    // Single frame 1,0,1,0,0,1,1,0
    send_frame(8'h65, 0, 0, 0);
    chk("single_y", y, 8'h65);
    chk("single_valid", {7'd0, valid}, 8'd1);
    step(1'b0, ~SYNC, 1'b0);
    chk("single_valid_drop", {7'd0, valid}, 8'd0);
    chk("single_y_hold", y, 8'h65);

    // Gapped strobes
    send_frame(8'h9A, 2, 0, 0);
    chk("gapped_y", y, 8'h9A);
    chk("gapped_valid", {7'd0, valid}, 8'd1);
    gap_cycles(2);
    chk("gapped_hold", y, 8'h9A);

    // Resync at slot 4
    send_partial(8'hFF, 4);
    chk("resync_slot", {5'd0, slot}, 8'd4);
    send_frame(8'h3C, 0, 1, 0);
    chk("resync_y", y, 8'h3C);
    chk("resync_valid", {7'd0, valid}, 8'd1);

    // Back-to-back frames
    send_frame(8'hA5, 0, 0, 0);
    chk("b2b_y0", y, 8'hA5);
    chk("b2b_valid0", {7'd0, valid}, 8'd1);
    send_frame(8'h3C, 0, 0, 0);
    chk("b2b_y1", y, 8'h3C);
    chk("b2b_valid1", {7'd0, valid}, 8'd1);

`ifdef DEMUX_PARITY_EN
    send_frame(8'h65, 0, 0, 0);
    chk("par_ok_y", y, 8'h65);
    chk("par_ok_valid", {7'd0, valid}, 8'd1);
    send_frame(8'h5A, 0, 0, 1);
    chk("par_bad_err", {7'd0, err}, 8'd1);
    chk("par_bad_y", y, 8'h65);
`endif

    // Asynchronous reset mid-frame
    send_partial(8'h0F, 4);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_y", y, 8'h00);
    chk("async_rst_slot", {5'd0, slot}, 8'd0);
    chk("async_rst_valid", {7'd0, valid}, 8'd0);
    chk("async_rst_err", {7'd0, err}, 8'd0);
    @(posedge clk); #1;
    step(1'b1, SYNC, 1'b1);
    rst_n = 1'b1;
    repeat (3) step(1'b1, ~SYNC, 1'b1);
    chk("post_rst_slot", {5'd0, slot}, 8'd0);
    send_frame(8'hC3, 0, 0, 0);
    chk("post_rst_y", y, 8'hC3);

    // Randomized strobes, syncs and data
    for (int i = 0; i < 3000; i++)
      step(1'($urandom_range(0, 9) < 7), ($urandom_range(0, 15) == 0) ? SYNC : ~SYNC,
           1'($urandom_range(0, 1)));

    @(negedge clk);
    checking = 0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
